// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM state type and index/tag width helpers for the split cache
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_D_FILL  = 2'd1,
    S_I_FILL  = 2'd2,
    S_D_WRITE = 2'd3
  } state_t;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines);
    return addr_w - $clog2(lines);
  endfunction

endpackage

// File: rtl/cache_dm_array.sv
// rtl/cache_dm_array.sv - direct-mapped one-word-per-line store with lookup, write and invalidate ports
module cache_dm_array
  import cache_pkg::*;
#(
  parameter int LINES  = 64,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_lk_addr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_wr_en,
  input  logic              i_wr_upd_only,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_inv_en,
  input  logic [ADDR_W-1:0] i_inv_addr
);

  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(ADDR_W, LINES);

  logic [LINES-1:0]  r_valid;
  logic [TW-1:0]     r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  logic [IW-1:0] w_lk_idx, w_wr_idx, w_inv_idx;
  logic [TW-1:0] w_lk_tag, w_wr_tag, w_inv_tag;
  logic          w_wr_match, w_wr_go, w_inv_go;

  assign w_lk_idx  = i_lk_addr[IW-1:0];
  assign w_lk_tag  = i_lk_addr[ADDR_W-1:IW];
  assign w_wr_idx  = i_wr_addr[IW-1:0];
  assign w_wr_tag  = i_wr_addr[ADDR_W-1:IW];
  assign w_inv_idx = i_inv_addr[IW-1:0];
  assign w_inv_tag = i_inv_addr[ADDR_W-1:IW];

  // Update-only writes (store hits) must never allocate a line that is absent.
  assign w_wr_match = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);
  assign w_wr_go    = i_wr_en && (!i_wr_upd_only || w_wr_match);
  assign w_inv_go   = i_inv_en && r_valid[w_inv_idx] && (r_tag[w_inv_idx] == w_inv_tag);

  assign o_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign o_data = r_data[w_lk_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (w_wr_go)  r_valid[w_wr_idx]  <= 1'b1;
      if (w_inv_go) r_valid[w_inv_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_go) begin
      r_tag[w_wr_idx]  <= w_wr_tag;
      r_data[w_wr_idx] <= i_wr_data;
    end
  end

endmodule

// File: rtl/cache_split_dm.sv
// rtl/cache_split_dm.sv - split I/D direct-mapped cache with one shared write-through backing port
module cache_split_dm
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int I_LINES = 64,
  parameter int D_LINES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_hit,
  output logic [DATA_W-1:0] instr,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] wrt_data,
  output logic              d_hit,
  output logic [DATA_W-1:0] d_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            r_state;
  logic              r_wr_done;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_i_line_hit, w_d_line_hit;
  logic [DATA_W-1:0] w_i_line_data, w_d_line_data;
  logic              w_i_fetch_hit, w_d_load_hit;
  logic              w_d_pend, w_i_fill_ack, w_d_fill_ack, w_wr_ack;
  logic [DATA_W-1:0] w_d_wr_data;

  assign w_i_fill_ack = (r_state == S_I_FILL)  && mem_ack;
  assign w_d_fill_ack = (r_state == S_D_FILL)  && mem_ack;
  assign w_wr_ack     = (r_state == S_D_WRITE) && mem_ack;
  assign w_d_wr_data  = w_wr_ack ? r_mem_wdata : mem_rdata;

  cache_dm_array #(.LINES(I_LINES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_i_array (
    .clk           (clk),
    .rst           (rst),
    .i_lk_addr     (i_addr),
    .o_hit         (w_i_line_hit),
    .o_data        (w_i_line_data),
    .i_wr_en       (w_i_fill_ack),
    .i_wr_upd_only (1'b0),
    .i_wr_addr     (r_mem_addr),
    .i_wr_data     (mem_rdata),
    .i_inv_en      (w_wr_ack),
    .i_inv_addr    (r_mem_addr)
  );

  cache_dm_array #(.LINES(D_LINES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_d_array (
    .clk           (clk),
    .rst           (rst),
    .i_lk_addr     (d_addr),
    .o_hit         (w_d_line_hit),
    .o_data        (w_d_line_data),
    .i_wr_en       (w_d_fill_ack || w_wr_ack),
    .i_wr_upd_only (w_wr_ack),
    .i_wr_addr     (r_mem_addr),
    .i_wr_data     (w_d_wr_data),
    .i_inv_en      (1'b0),
    .i_inv_addr    (r_mem_addr)
  );

  assign w_i_fetch_hit = i_re && w_i_line_hit;
  assign w_d_load_hit  = d_re && w_d_line_hit;
  // r_wr_done masks the still-held d_we so a finished store is not reissued.
  assign w_d_pend      = (d_re && !w_d_line_hit) || (d_we && !r_wr_done);

  assign i_hit     = w_i_fetch_hit;
  assign instr     = w_i_fetch_hit ? w_i_line_data : '0;
  assign d_hit     = w_d_load_hit || (d_we && r_wr_done);
  assign d_data    = w_d_load_hit ? w_d_line_data : '0;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_done   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_wr_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (d_we && !r_wr_done) begin
            r_state     <= S_D_WRITE;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= wrt_data;
          end else if (d_re && !w_d_line_hit) begin
            r_state    <= S_D_FILL;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= d_addr;
          end else if (i_re && !w_i_line_hit && !w_d_pend) begin
            r_state    <= S_I_FILL;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= i_addr;
          end
        end
        S_D_FILL, S_I_FILL: begin
          if (mem_ack) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        S_D_WRITE: begin
          if (mem_ack) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_wr_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
